// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button front end: clock rate, lane map and default timings.
package button_conditioner_pkg;

  localparam int unsigned CLK_HZ = 100000000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned BTN_RESET = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_RIGHT = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = ms_to_cycles(20);
  localparam int unsigned DEF_REPEAT_DELAY    = ms_to_cycles(500);
  localparam int unsigned DEF_REPEAT_PERIOD   = ms_to_cycles(100);

endpackage

// File: rtl/button_conditioner_lane.sv
// One button lane: 2-flop synchronizer, stable-count debounce, press/release pulses, auto-repeat FSM.
module btn_lane
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic press_nxt_o
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rep_state_e;

  logic [1:0]    sync_q;
  logic          s;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          accept, press_d, release_d;
  logic          press_q, release_q, repeat_q, repeat_d;
  rep_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  assign s         = sync_q[1];
  assign accept    = (s != level_q) && (dcnt_q == DCNT_LAST);
  assign press_d   = accept & s;
  assign release_d = accept & ~s;

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (s == level_q) begin
      dcnt_d = '0;
    end else if (accept) begin
      level_d = s;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // Release overrides any repeat due in the same cycle so the two never collide.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_d) begin
          state_d = S_DELAY;
          rcnt_d  = '0;
        end
      end
      S_DELAY: begin
        if (rcnt_q == DELAY_LAST) begin
          repeat_d = 1'b1;
          state_d  = S_REPEAT;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (rcnt_q == PER_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
    if (release_d || !REPEAT_EN) begin
      state_d  = S_IDLE;
      rcnt_d   = '0;
      repeat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign repeat_o    = repeat_q;
  assign press_nxt_o = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BTN independent lanes plus a registered any-press summary.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned        NUM_BTN         = 5,
  parameter int unsigned        DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned        REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned        REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_EN       = 5'b01100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               any_press
);

  logic [NUM_BTN-1:0] press_nxt;
  logic               any_press_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_EN[i])
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .raw_i      (btn_raw[i]),
      .level_o    (btn_level[i]),
      .press_o    (btn_press[i]),
      .release_o  (btn_release[i]),
      .repeat_o   (btn_repeat[i]),
      .press_nxt_o(press_nxt[i])
    );
  end

  // Built from next-cycle press terms so any_press lines up with btn_press.
  always_ff @(posedge clk) begin
    if (reset) any_press_q <= 1'b0;
    else       any_press_q <= |press_nxt;
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor pops and compares them.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
  logic       any_press;

  button_conditioner #(
    .NUM_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(5'b01100)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] rep;
    logic       any;
  } ev_t;

  ev_t exp_q[$];
  int  s_pass = 0, s_tot = 0;
  int  m_pass = 0, m_tot = 0;

  function automatic void push(input int c, input logic [4:0] p, input logic [4:0] r, input logic [4:0] rp);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = rp; e.any = |p;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if ((|btn_press) || (|btn_release) || (|btn_repeat) || any_press) begin
      m_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b rep=%b any=%b", cyc, btn_press, btn_release, btn_repeat, any_press);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || btn_press != e.press || btn_release != e.rel || btn_repeat != e.rep || any_press != e.any)
          $display("FAIL pulse_event got cyc=%0d p=%b r=%b rp=%b a=%b want cyc=%0d p=%b r=%b rp=%b a=%b",
                   cyc, btn_press, btn_release, btn_repeat, any_press, e.cyc, e.press, e.rel, e.rep, e.any);
        else m_pass++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    s_tot++;
    if (act !== exp) $display("FAIL %s got=%0h want=%0h", name, act, exp);
    else s_pass++;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int c, p, r;
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {btn_level, btn_press, btn_release, btn_repeat, any_press}, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // clean press on lane 1, held 30 cycles with repeat disabled
    c = cyc; btn_raw[1] = 1'b1; p = c + 6;
    push(p, 5'b00010, 5'b0, 5'b0);
    go_to(p - 1); chk("lvl1_before", btn_level[1], 1'b0);
    go_to(p);     chk("lvl1_accept", btn_level[1], 1'b1);
    go_to(p + 30); btn_raw[1] = 1'b0;
    push(p + 36, 5'b0, 5'b00010, 5'b0);
    go_to(p + 37); chk("lvl1_released", btn_level[1], 1'b0);

    // glitch on lane 4 (3 cycles), then a 4-cycle stable high
    c = cyc; btn_raw[4] = 1'b1;
    go_to(c + 3); btn_raw[4] = 1'b0;
    go_to(c + 12); chk("lvl4_glitch", btn_level[4], 1'b0);
    c = cyc; btn_raw[4] = 1'b1;
    push(c + 6, 5'b10000, 5'b0, 5'b0);
    go_to(c + 4); btn_raw[4] = 1'b0;
    push(c + 10, 5'b0, 5'b10000, 5'b0);
    go_to(c + 12); chk("lvl4_after", btn_level[4], 1'b0);

    // auto-repeat on lane 2; release lands where a repeat would have been due
    c = cyc; btn_raw[2] = 1'b1; p = c + 6;
    push(p, 5'b00100, 5'b0, 5'b0);
    for (int i = 0; i < 7; i++) push(p + 10 + 3 * i, 5'b0, 5'b0, 5'b00100);
    go_to(p + 25); btn_raw[2] = 1'b0;
    push(p + 31, 5'b0, 5'b00100, 5'b0);
    go_to(p + 40); chk("lvl2_released", btn_level[2], 1'b0);

    // reset mid-count on lane 3
    c = cyc; btn_raw[3] = 1'b1;
    go_to(c + 4); reset = 1'b1;
    go_to(c + 5);
    chk("reset_mid", {btn_level, btn_press, btn_release, btn_repeat, any_press}, '0);
    go_to(c + 6); reset = 1'b0; r = cyc;
    push(r + 6, 5'b01000, 5'b0, 5'b0);
    go_to(r + 5); chk("lvl3_pre", btn_level[3], 1'b0);
    go_to(r + 6); chk("lvl3_accept", btn_level[3], 1'b1);
    btn_raw[3] = 1'b0;
    push(r + 12, 5'b0, 5'b01000, 5'b0);
    go_to(r + 14);

    // simultaneous presses on lanes 0 and 2
    c = cyc; btn_raw[0] = 1'b1; btn_raw[2] = 1'b1;
    push(c + 6, 5'b00101, 5'b0, 5'b0);
    go_to(c + 6); chk("lvl_simul", btn_level, 5'b00101);
    btn_raw[0] = 1'b0; btn_raw[2] = 1'b0;
    push(c + 12, 5'b0, 5'b00101, 5'b0);
    go_to(c + 16);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", s_pass + m_pass, s_tot + m_tot);
    $finish;
  end

endmodule
